// File: rtl/csr_encoder.sv
// csr_encoder: streams a dense row-major matrix in and builds its CSR form
// (NV values, CI column indices, RP row pointers) for the sparse multiplier.
module csr_encoder #(
  parameter int data_width_param   = 32,
  parameter int max_elements_param = 16,
  parameter int idx_width_param    = 4
) (
  input  logic                                                 clk_i,
  input  logic                                                 rst_i,
  input  logic                                                 start_i,
  input  logic [idx_width_param-1:0]                           rows_i,
  input  logic [idx_width_param-1:0]                           cols_i,
  input  logic                                                 elem_valid_i,
  input  logic [data_width_param-1:0]                          elem_i,
  output logic                                                 elem_ready_o,
  output logic [0:max_elements_param-1][data_width_param-1:0]  NV_o,
  output logic [0:max_elements_param-1][idx_width_param-1:0]   CI_o,
  output logic [0:max_elements_param-1][idx_width_param-1:0]   RP_o,
  output logic [idx_width_param-1:0]                           nnz_o,
  output logic                                                 busy_o,
  output logic                                                 done_o,
  output logic                                                 overflow_o
);

  localparam int IW = idx_width_param;
  localparam int DW = data_width_param;
  localparam int ME = max_elements_param;

  // Capacity is all-ones so the final row pointer always fits in IW bits.
  localparam logic [IW-1:0] CAP = '1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t        state;
  logic [IW-1:0] rows_q, cols_q, row_q, col_q;

  logic          clr, accept, elem_nz, store, last_col, last_row, row_end;
  logic [IW-1:0] nnz_next, rp_idx;

  assign clr      = (state == IDLE) && start_i;
  assign accept   = elem_valid_i && elem_ready_o;
  assign elem_nz  = |elem_i;
  assign store    = accept && elem_nz && (nnz_o != CAP);
  assign nnz_next = nnz_o + {{(IW-1){1'b0}}, store};
  assign last_col = (col_q == cols_q - 1'b1);
  assign last_row = (row_q == rows_q - 1'b1);
  assign row_end  = accept && last_col;
  // row_q never exceeds rows-2 when a row ends early, so rp_idx is always >= 1
  // and RP[0] is never written.
  assign rp_idx   = row_q + 1'b1;

  // Per-entry storage: each slot owns its write enable against nnz / rp_idx.
  for (genvar i = 0; i < ME; i++) begin : g_entry
    logic [DW-1:0] nv_e;
    logic [IW-1:0] ci_e, rp_e;

    // NV/CI slot fills when it is the next free position; RP slot on row end.
    always_ff @(posedge clk_i) begin
      if (rst_i || clr) begin
        nv_e <= '0;
        ci_e <= '0;
        rp_e <= '0;
      end else begin
        if (store && (nnz_o == IW'(i))) begin
          nv_e <= elem_i;
          ci_e <= col_q;
        end
        if (row_end && (rp_idx == IW'(i)))
          rp_e <= nnz_next;
      end
    end

    assign NV_o[i] = nv_e;
    assign CI_o[i] = ci_e;
    assign RP_o[i] = rp_e;
  end

  // Control FSM: walks row/col over the latched shape, registered handshakes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      rows_q       <= '0;
      cols_q       <= '0;
      row_q        <= '0;
      col_q        <= '0;
      nnz_o        <= '0;
      elem_ready_o <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      overflow_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            rows_q     <= rows_i;
            cols_q     <= cols_i;
            row_q      <= '0;
            col_q      <= '0;
            nnz_o      <= '0;
            overflow_o <= 1'b0;
            if (rows_i == '0 || cols_i == '0) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else begin
              state        <= LOAD;
              elem_ready_o <= 1'b1;
              busy_o       <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            nnz_o <= nnz_next;
            if (elem_nz && (nnz_o == CAP))
              overflow_o <= 1'b1;
            if (last_col) begin
              col_q <= '0;
              if (last_row) begin
                state        <= DONE;
                elem_ready_o <= 1'b0;
                busy_o       <= 1'b0;
                done_o       <= 1'b1;
              end else begin
                row_q <= row_q + 1'b1;
              end
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        DONE: begin
          done_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_encoder.sv
// Bench for csr_encoder: directed test-plan matrices plus random shapes checked
// against a row/col loop model of the CSR rules.
module tb_csr_encoder;
  localparam int DW = 32;
  localparam int ME = 16;
  localparam int IW = 4;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic                       start = 1'b0;
  logic [IW-1:0]              rows = '0, cols = '0;
  logic                       ev = 1'b0;
  logic [DW-1:0]              elem = '0;
  logic                       ready, busy, done, overflow;
  logic [0:ME-1][DW-1:0]      nv;
  logic [0:ME-1][IW-1:0]      ci, rp;
  logic [IW-1:0]              nnz;

  csr_encoder #(.data_width_param(DW), .max_elements_param(ME), .idx_width_param(IW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .rows_i(rows), .cols_i(cols),
    .elem_valid_i(ev), .elem_i(elem), .elem_ready_o(ready),
    .NV_o(nv), .CI_o(ci), .RP_o(rp), .nnz_o(nnz),
    .busy_o(busy), .done_o(done), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int mat_a [16] = '{0,0,1,0, 0,5,7,0, 9,0,0,4, 2,6,0,0};
  int mat_b [16] = '{1,0,3,1, 0,0,0,0, 2,0,2,0, 0,1,5,7};

  localparam logic [ME*DW-1:0] A_NV = {32'd1,32'd5,32'd7,32'd9,32'd4,32'd2,32'd6,288'd0};
  localparam logic [ME*IW-1:0] A_CI = {4'd2,4'd1,4'd2,4'd0,4'd3,4'd0,4'd1,36'd0};
  localparam logic [ME*IW-1:0] A_RP = {4'd0,4'd1,4'd3,4'd5,4'd7,44'd0};
  localparam logic [ME*DW-1:0] B_NV = {32'd1,32'd3,32'd1,32'd2,32'd2,32'd1,32'd5,32'd7,256'd0};
  localparam logic [ME*IW-1:0] B_CI = {4'd0,4'd2,4'd3,4'd0,4'd2,4'd1,4'd2,4'd3,32'd0};
  localparam logic [ME*IW-1:0] B_RP = {4'd0,4'd3,4'd3,4'd5,4'd8,44'd0};
  localparam logic [ME*IW-1:0] O_RP = {4'd0,4'd4,4'd8,4'd12,4'd15,44'd0};

  logic [DW-1:0] mat [256];

  // reference results
  logic [0:ME-1][DW-1:0] exp_nv;
  logic [0:ME-1][IW-1:0] exp_ci, exp_rp;
  int                    exp_nnz;
  logic                  exp_ovf;

  // observations from the driver
  bit obs_timeout, obs_busy_k1, obs_ready_k1, obs_ready_ok, obs_done_early;
  bit obs_done_n1, obs_done_n2, obs_ready_n1, obs_busy_n1, obs_ovf_before;
  int obs_cyc;

  task automatic load_mat(input int src [16]);
    for (int i = 0; i < 16; i++) mat[i] = DW'(src[i]);
  endtask

  // CSR rules applied directly to the dense matrix.
  task automatic model(input int r, input int c);
    exp_nv = '0; exp_ci = '0; exp_rp = '0; exp_nnz = 0; exp_ovf = 1'b0;
    for (int i = 0; i < r; i++) begin
      for (int j = 0; j < c; j++) begin
        if (mat[i*c+j] != 0) begin
          if (exp_nnz < 15) begin
            exp_nv[exp_nnz] = mat[i*c+j];
            exp_ci[exp_nnz] = IW'(j);
            exp_nnz++;
          end else begin
            exp_ovf = 1'b1;
          end
        end
      end
      exp_rp[i+1] = IW'(exp_nnz);
    end
  endtask

  // Drives one encode; stop_after >= 0 abandons after that many accepts.
  task automatic run_encode(input int r, input int c, input int bubble_pct,
                            input int stop_after, input bit mid_start);
    int idx, lim;
    bit v;
    lim = (stop_after >= 0) ? stop_after : r*c;
    @(negedge clk); start = 1'b1; rows = IW'(r); cols = IW'(c);
    @(negedge clk); start = 1'b0; rows = IW'($urandom); cols = IW'($urandom);
    obs_busy_k1 = busy; obs_ready_k1 = ready;
    idx = 0; obs_cyc = 0; obs_ready_ok = 1; obs_done_early = 0; obs_ovf_before = 0;
    while (idx < lim && obs_cyc < 2000) begin
      if (!ready) obs_ready_ok = 0;
      if (done) obs_done_early = 1;
      v = ($urandom_range(99) >= bubble_pct);
      if (mid_start && idx == 5) begin start = 1'b1; rows = 1; cols = 1; end
      else start = 1'b0;
      ev = v; elem = mat[idx];
      if (v && idx == r*c-1) obs_ovf_before = overflow;
      @(negedge clk);
      if (v) idx++;
      obs_cyc++;
    end
    ev = 1'b0; start = 1'b0; elem = $urandom;
    obs_timeout = (idx < lim);
    if (stop_after < 0) begin
      obs_done_n1 = done; obs_ready_n1 = ready; obs_busy_n1 = busy;
      @(negedge clk);
      obs_done_n2 = done;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if ({nv, ci, rp} !== '0) begin n_fail++; $display("FAIL reset_arrays: got nonzero nv=%h", nv); end
    n_checks++; if ({nnz, ready, busy, done, overflow} !== '0) begin n_fail++; $display("FAIL reset_ctrl: got %b want 0", {nnz, ready, busy, done, overflow}); end
    rst = 1'b0;
  endtask

  task automatic test_matrix_a();
    load_mat(mat_a);
    run_encode(4, 4, 0, -1, 0);
    n_checks++; if (obs_timeout) begin n_fail++; $display("FAIL a_timeout: encode did not finish"); end
    n_checks++; if ({obs_busy_k1, obs_ready_k1} !== 2'b11) begin n_fail++; $display("FAIL a_start: busy/ready got %b want 11", {obs_busy_k1, obs_ready_k1}); end
    n_checks++; if (nv !== A_NV) begin n_fail++; $display("FAIL a_nv: got %h want %h", nv, A_NV); end
    n_checks++; if (ci !== A_CI) begin n_fail++; $display("FAIL a_ci: got %h want %h", ci, A_CI); end
    n_checks++; if (rp !== A_RP) begin n_fail++; $display("FAIL a_rp: got %h want %h", rp, A_RP); end
    n_checks++; if (nnz !== 4'd7) begin n_fail++; $display("FAIL a_nnz: got %0d want 7", nnz); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL a_ovf: got %b want 0", overflow); end
    n_checks++; if ({obs_done_early, obs_done_n1, obs_done_n2} !== 3'b010) begin n_fail++; $display("FAIL a_done: early/n1/n2 got %b want 010", {obs_done_early, obs_done_n1, obs_done_n2}); end
    n_checks++; if ({obs_ready_ok, obs_ready_n1, obs_busy_n1} !== 3'b100) begin n_fail++; $display("FAIL a_ready: ok/n1/busy got %b want 100", {obs_ready_ok, obs_ready_n1, obs_busy_n1}); end
    n_checks++; if (obs_cyc !== 16) begin n_fail++; $display("FAIL a_cycles: got %0d want 16", obs_cyc); end
  endtask

  task automatic test_matrix_b_bubbles();
    load_mat(mat_b);
    run_encode(4, 4, 40, -1, 0);
    n_checks++; if (obs_timeout) begin n_fail++; $display("FAIL b_timeout: encode did not finish"); end
    n_checks++; if (nv !== B_NV) begin n_fail++; $display("FAIL b_nv: got %h want %h", nv, B_NV); end
    n_checks++; if (ci !== B_CI) begin n_fail++; $display("FAIL b_ci: got %h want %h", ci, B_CI); end
    n_checks++; if (rp !== B_RP) begin n_fail++; $display("FAIL b_rp: got %h want %h", rp, B_RP); end
    n_checks++; if (nnz !== 4'd8) begin n_fail++; $display("FAIL b_nnz: got %0d want 8", nnz); end
    n_checks++; if ({obs_done_early, obs_done_n1, obs_done_n2} !== 3'b010) begin n_fail++; $display("FAIL b_done: got %b want 010", {obs_done_early, obs_done_n1, obs_done_n2}); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) mat[i] = 32'hFFFF_FFFF;
    run_encode(4, 4, 0, -1, 0);
    n_checks++; if (obs_timeout) begin n_fail++; $display("FAIL ovf_timeout: encode did not finish"); end
    n_checks++; if (nnz !== 4'd15) begin n_fail++; $display("FAIL ovf_nnz: got %0d want 15", nnz); end
    n_checks++; if ({obs_ovf_before, overflow} !== 2'b01) begin n_fail++; $display("FAIL ovf_flag: before/after got %b want 01", {obs_ovf_before, overflow}); end
    n_checks++; if (rp !== O_RP) begin n_fail++; $display("FAIL ovf_rp: got %h want %h", rp, O_RP); end
    n_checks++; if ({ci[12], ci[13], ci[14]} !== {4'd0, 4'd1, 4'd2}) begin n_fail++; $display("FAIL ovf_ci: got %h want 012", {ci[12], ci[13], ci[14]}); end
  endtask

  task automatic test_zero_dim();
    @(negedge clk); start = 1'b1; rows = 0; cols = 4;
    @(negedge clk); start = 1'b0;
    n_checks++; if ({done, ready, busy} !== 3'b100) begin n_fail++; $display("FAIL zd_k1: done/ready/busy got %b want 100", {done, ready, busy}); end
    @(negedge clk);
    n_checks++; if ({done, ready, busy} !== 3'b000) begin n_fail++; $display("FAIL zd_k2: done/ready/busy got %b want 000", {done, ready, busy}); end
    n_checks++; if ({nv, ci, rp, nnz, overflow} !== '0) begin n_fail++; $display("FAIL zd_cleared: got rp=%h nnz=%0d ovf=%b", rp, nnz, overflow); end
  endtask

  task automatic test_reset_mid();
    load_mat(mat_a);
    run_encode(4, 4, 0, 6, 0);
    n_checks++; if ({nnz, busy} !== {4'd2, 1'b1}) begin n_fail++; $display("FAIL rm_partial: nnz/busy got %0d/%b want 2/1", nnz, busy); end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    n_checks++; if ({nv, ci, rp, nnz, ready, busy, done, overflow} !== '0) begin n_fail++; $display("FAIL rm_reset: got rp=%h nnz=%0d ready=%b busy=%b", rp, nnz, ready, busy); end
    run_encode(4, 4, 0, -1, 0);
    n_checks++; if ({nv, ci, rp} !== {A_NV, A_CI, A_RP}) begin n_fail++; $display("FAIL rm_result: got rp=%h ci=%h want rp=%h ci=%h", rp, ci, A_RP, A_CI); end
    n_checks++; if ({nnz, obs_done_n1} !== {4'd7, 1'b1}) begin n_fail++; $display("FAIL rm_nnz_done: got %0d/%b want 7/1", nnz, obs_done_n1); end
  endtask

  task automatic test_start_busy_hold();
    load_mat(mat_a);
    run_encode(4, 4, 0, -1, 1);
    n_checks++; if ({nv, ci, rp} !== {A_NV, A_CI, A_RP}) begin n_fail++; $display("FAIL sb_result: got rp=%h ci=%h want rp=%h ci=%h", rp, ci, A_RP, A_CI); end
    n_checks++; if ({obs_cyc, obs_done_n1} !== {32'd16, 1'b1}) begin n_fail++; $display("FAIL sb_timing: cyc/done got %0d/%b want 16/1", obs_cyc, obs_done_n1); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); ev = 1'b1; elem = 32'h55;
    end
    @(negedge clk); ev = 1'b0;
    n_checks++; if ({nv, ci, rp, nnz} !== {A_NV, A_CI, A_RP, 4'd7}) begin n_fail++; $display("FAIL hold: got rp=%h nnz=%0d want rp=%h nnz=7", rp, nnz, A_RP); end
    n_checks++; if ({ready, busy, done} !== 3'b000) begin n_fail++; $display("FAIL hold_ctrl: got %b want 000", {ready, busy, done}); end
  endtask

  task automatic test_random();
    int r, c;
    for (int t = 0; t < 8; t++) begin
      r = $urandom_range(5, 1);
      c = $urandom_range(5, 1);
      for (int i = 0; i < r*c; i++) mat[i] = ($urandom_range(99) < 45) ? '0 : $urandom;
      model(r, c);
      run_encode(r, c, 30, -1, 0);
      n_checks++; if (obs_timeout) begin n_fail++; $display("FAIL rnd%0d_timeout: %0dx%0d did not finish", t, r, c); end
      n_checks++; if (nv !== exp_nv) begin n_fail++; $display("FAIL rnd%0d_nv: got %h want %h", t, nv, exp_nv); end
      n_checks++; if ({ci, rp} !== {exp_ci, exp_rp}) begin n_fail++; $display("FAIL rnd%0d_ci_rp: got %h/%h want %h/%h", t, ci, rp, exp_ci, exp_rp); end
      n_checks++; if ({nnz, overflow} !== {IW'(exp_nnz), exp_ovf}) begin n_fail++; $display("FAIL rnd%0d_nnz_ovf: got %0d/%b want %0d/%b", t, nnz, overflow, exp_nnz, exp_ovf); end
      n_checks++; if ({obs_done_early, obs_done_n1, obs_done_n2} !== 3'b010) begin n_fail++; $display("FAIL rnd%0d_done: got %b want 010", t, {obs_done_early, obs_done_n1, obs_done_n2}); end
    end
  endtask

  initial begin
    test_reset();
    test_matrix_a();
    test_matrix_b_bubbles();
    test_overflow();
    test_zero_dim();
    test_reset_mid();
    test_start_busy_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
